vgachargen_apb_bridge: RTL and testbench

APB4 completer that translates bus transfers into accesses on the three vgachargen memory ports: char map, colour map and char tiff (font). It is the bus-side initiator for those ports, replacing bench-driven stimulus in the apb_vgachargen top. Shared addr/we/be/wdata fan out to all three memories, with a per-memory chip-enable; read data returns one cycle after ce.

---
 rtl/vgachargen_pkg.sv | 63 ++++++
 rtl/vgachargen_apb_bridge.sv | 153 +++++++++++++++
 tb/tb_vgachargen_apb_bridge.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vgachargen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vgachargen_pkg
// Brief    : Shared types, constants and address decode for the vgachargen
//            APB bridge. Optional ID register: VGACHARGEN_APB_ID_REG_EN.
// Revision : 1.0
// ============================================================================
package vgachargen_pkg;

    localparam int unsigned CH_MAP_WORDS_DEF  = 600;
    localparam int unsigned COL_MAP_WORDS_DEF = 600;
    localparam int unsigned CH_T_WORDS_DEF    = 1024;

    localparam logic [31:0] ID_VALUE = 32'h5647_4331;

    typedef enum logic [1:0] {
        CH_MAP  = 2'd0,
        COL_MAP = 2'd1,
        CH_T    = 2'd2,
        INVALID = 2'd3
    } region_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } bridge_state_e;

    typedef struct packed {
        region_e    region;
        logic [9:0] word;
        logic       err;
    } decode_t;

    // Only the low 14 address bits carry region/word/alignment information.
    function automatic decode_t decode_addr(
        input logic [13:0] paddr,
        input int unsigned ch_words,
        input int unsigned col_words,
        input int unsigned cht_words
    );
        decode_t d;
        d.region = region_e'(paddr[13:12]);
        d.word   = paddr[11:2];
        d.err    = (paddr[1:0] != 2'b00);
        case (d.region)
            CH_MAP:  if (32'(d.word) >= ch_words)  d.err = 1'b1;
            COL_MAP: if (32'(d.word) >= col_words) d.err = 1'b1;
            CH_T:    if (32'(d.word) >= cht_words) d.err = 1'b1;
            default: begin
`ifdef VGACHARGEN_APB_ID_REG_EN
                if (d.word != 10'd0) d.err = 1'b1;
`else
                d.err = 1'b1;
`endif
            end
        endcase
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vgachargen_apb_bridge.sv
`default_nettype none
// ============================================================================
// Module   : vgachargen_apb_bridge
// Brief    : APB4 completer driving the char map, colour map and char tiff
//            memory ports. Optional ID register: VGACHARGEN_APB_ID_REG_EN.
// Revision : 1.0
// ============================================================================
module vgachargen_apb_bridge
    import vgachargen_pkg::*;
#(
    parameter int unsigned CH_MAP_WORDS  = CH_MAP_WORDS_DEF,
    parameter int unsigned COL_MAP_WORDS = COL_MAP_WORDS_DEF,
    parameter int unsigned CH_T_WORDS    = CH_T_WORDS_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        psel_i,
    input  logic        penable_i,
    input  logic        pwrite_i,
    input  logic [31:0] paddr_i,
    input  logic [31:0] pwdata_i,
    input  logic [3:0]  pstrb_i,
    output logic [31:0] prdata_o,
    output logic        pready_o,
    output logic        pslverr_o,
    output logic [9:0]  mem_addr_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    output logic        char_map_ce_o,
    output logic        col_map_ce_o,
    output logic        char_tiff_ce_o,
    input  logic [31:0] char_map_rdata_i,
    input  logic [31:0] col_map_rdata_i,
    input  logic [31:0] char_tiff_rdata_i
);

    bridge_state_e state_q, state_d;
    region_e       region_q;
    logic          write_q;
    logic          err_q, err_d;
    logic [3:0]    strb_q;
    logic [9:0]    addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   prdata_q;
    logic          pready_q;
    logic          pslverr_q;

    decode_t       dec;
    logic          setup;
    logic          req_err;
    logic [31:0]   rdata_sel;
    logic          unused_paddr;

    assign unused_paddr = ^paddr_i[31:14];

    assign setup = (state_q == IDLE) && psel_i && !penable_i;
    assign dec   = decode_addr(paddr_i[13:0], CH_MAP_WORDS, COL_MAP_WORDS, CH_T_WORDS);
    // Region 3 is never writable, even where the ID register is present.
    assign req_err = dec.err || ((dec.region == INVALID) && pwrite_i);
    assign err_d   = setup ? req_err : err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (setup) state_d = req_err ? RESP : ISSUE;
            ISSUE:   state_d = write_q ? RESP : WAIT;
            WAIT:    state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        char_map_ce_o  = 1'b0;
        col_map_ce_o   = 1'b0;
        char_tiff_ce_o = 1'b0;
        mem_we_o       = 1'b0;
        mem_be_o       = 4'b0000;
        if (state_q == ISSUE) begin
            case (region_q)
                CH_MAP:  char_map_ce_o  = 1'b1;
                COL_MAP: col_map_ce_o   = 1'b1;
                CH_T:    char_tiff_ce_o = 1'b1;
                default: ;
            endcase
            if (write_q) begin
                mem_we_o = |strb_q;
                mem_be_o = strb_q;
            end
        end
    end

    always_comb begin
        rdata_sel = '0;
        case (region_q)
            CH_MAP:  rdata_sel = char_map_rdata_i;
            COL_MAP: rdata_sel = col_map_rdata_i;
            CH_T:    rdata_sel = char_tiff_rdata_i;
            default: begin
`ifdef VGACHARGEN_APB_ID_REG_EN
                rdata_sel = ID_VALUE;
`else
                rdata_sel = '0;
`endif
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            region_q  <= CH_MAP;
            write_q   <= 1'b0;
            err_q     <= 1'b0;
            strb_q    <= 4'b0000;
            addr_q    <= '0;
            wdata_q   <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            pready_q  <= (state_d == RESP);
            pslverr_q <= (state_d == RESP) && err_d;
            if (setup) begin
                region_q <= dec.region;
                write_q  <= pwrite_i;
                err_q    <= req_err;
                strb_q   <= pstrb_i;
                // Memory-facing address/data only move for accesses that issue.
                if (!req_err) addr_q <= dec.word;
                if (!req_err && pwrite_i) wdata_q <= pwdata_i;
                if (req_err && !pwrite_i) prdata_q <= '0;
            end
            if (state_q == WAIT) prdata_q <= rdata_sel;
        end
    end

    assign prdata_o    = prdata_q;
    assign pready_o    = pready_q;
    assign pslverr_o   = pslverr_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_vgachargen_apb_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_vgachargen_apb_bridge
// Brief    : Directed self-checking bench for vgachargen_apb_bridge with
//            behavioural memories. Honours VGACHARGEN_APB_ID_REG_EN.
// Revision : 1.0
// ============================================================================
module tb_vgachargen_apb_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0] paddr = '0, pwdata = '0;
    logic [3:0]  pstrb = '0;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic [9:0]  mem_addr;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        cm_ce, col_ce, ct_ce;
    logic [31:0] cm_rd, col_rd, ct_rd;

    logic [31:0] cm_mem  [0:1023];
    logic [31:0] col_mem [0:1023];
    logic [31:0] ct_mem  [0:1023];

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] rd;
    logic        err;
    int          lat;
    logic [2:0]  ce1;
    logic        we1;
    logic [9:0]  a1;
    logic [3:0]  be1;
    logic [31:0] wd1;
    int          ce_cnt;

    vgachargen_apb_bridge dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .psel_i            (psel),
        .penable_i         (penable),
        .pwrite_i          (pwrite),
        .paddr_i           (paddr),
        .pwdata_i          (pwdata),
        .pstrb_i           (pstrb),
        .prdata_o          (prdata),
        .pready_o          (pready),
        .pslverr_o         (pslverr),
        .mem_addr_o        (mem_addr),
        .mem_we_o          (mem_we),
        .mem_be_o          (mem_be),
        .mem_wdata_o       (mem_wdata),
        .char_map_ce_o     (cm_ce),
        .col_map_ce_o      (col_ce),
        .char_tiff_ce_o    (ct_ce),
        .char_map_rdata_i  (cm_rd),
        .col_map_rdata_i   (col_rd),
        .char_tiff_rdata_i (ct_rd)
    );

    always #5 clk = ~clk;

    // Synchronous RAMs: byte-masked write, read data one cycle after ce.
    always @(posedge clk) begin
        if (cm_ce) begin
            for (int b = 0; b < 4; b++)
                if (mem_we && mem_be[b]) cm_mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            cm_rd <= cm_mem[mem_addr];
        end
        if (col_ce) begin
            for (int b = 0; b < 4; b++)
                if (mem_we && mem_be[b]) col_mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            col_rd <= col_mem[mem_addr];
        end
        if (ct_ce) begin
            for (int b = 0; b < 4; b++)
                if (mem_we && mem_be[b]) ct_mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            ct_rd <= ct_mem[mem_addr];
        end
    end

    // One APB transfer; lat counts access-phase cycles until pready (-1 = timeout).
    task automatic apb_xfer(input logic wr, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [3:0] strb);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd; pstrb = strb;
        @(negedge clk);
        penable = 1'b1;
        lat = -1; ce_cnt = 0; rd = '0; err = 1'b0;
        ce1 = '0; we1 = 1'b0; a1 = '0; be1 = '0; wd1 = '0;
        for (int n = 1; n <= 8; n++) begin
            if (n > 1) @(negedge clk);
            if (cm_ce || col_ce || ct_ce) ce_cnt++;
            if (n == 1) begin
                ce1 = {cm_ce, col_ce, ct_ce};
                we1 = mem_we; a1 = mem_addr; be1 = mem_be; wd1 = mem_wdata;
            end
            if (pready) begin
                lat = n; rd = prdata; err = pslverr;
                break;
            end
        end
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        vectors++; if ({pready, pslverr} !== 2'b00) begin miscompares++; $display("FAIL reset_resp got %b exp 00", {pready, pslverr}); end
        vectors++; if (prdata !== 32'h0) begin miscompares++; $display("FAIL reset_prdata got %h exp 0", prdata); end
        vectors++; if ({cm_ce, col_ce, ct_ce, mem_we, mem_be} !== 8'h00) begin miscompares++; $display("FAIL reset_ctl got %b exp 0", {cm_ce, col_ce, ct_ce, mem_we, mem_be}); end
        vectors++; if ({mem_addr, mem_wdata} !== 42'h0) begin miscompares++; $display("FAIL reset_addr_wdata got %h/%h exp 0/0", mem_addr, mem_wdata); end
    endtask

    task automatic test_enable_no_setup();
        int hits;
        hits = 0;
        @(negedge clk);
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'h1; pstrb = 4'hF;
        repeat (4) begin
            @(negedge clk);
            if (pready || cm_ce || col_ce || ct_ce) hits++;
        end
        psel = 1'b0; penable = 1'b0;
        vectors++; if (hits !== 0) begin miscompares++; $display("FAIL enable_no_setup activity got %0d exp 0", hits); end
    endtask

    task automatic test_write_basic();
        apb_xfer(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
        vectors++; if (lat !== 2) begin miscompares++; $display("FAIL wr_basic_lat got %0d exp 2", lat); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL wr_basic_err got %b exp 0", err); end
        vectors++; if ({ce1, we1, be1} !== {3'b100, 1'b1, 4'hF}) begin miscompares++; $display("FAIL wr_basic_ctl got %b exp 10011111", {ce1, we1, be1}); end
        vectors++; if ({a1, wd1} !== {10'd4, 32'hDEAD_BEEF}) begin miscompares++; $display("FAIL wr_basic_addr_data got %0d/%h exp 4/deadbeef", a1, wd1); end
        apb_xfer(1'b0, 32'h0000_0010, 32'h0, 4'h0);
        vectors++; if ({lat, err, rd} !== {32'd3, 1'b0, 32'hDEAD_BEEF}) begin miscompares++; $display("FAIL rd_basic got lat %0d err %b data %h exp 3 0 deadbeef", lat, err, rd); end
        vectors++; if ({ce1, we1, be1} !== {3'b100, 1'b0, 4'h0}) begin miscompares++; $display("FAIL rd_basic_ctl got %b exp 10000000", {ce1, we1, be1}); end
    endtask

    task automatic test_colmap_bounds();
        apb_xfer(1'b1, 32'h0000_195C, 32'h1234_5678, 4'hF);
        vectors++; if ({lat, err, ce1, a1} !== {32'd2, 1'b0, 3'b010, 10'd599}) begin miscompares++; $display("FAIL col_wr599 got lat %0d err %b ce %b addr %0d exp 2 0 010 599", lat, err, ce1, a1); end
        apb_xfer(1'b1, 32'h0000_1FFC, 32'hFFFF_FFFF, 4'hF);
        vectors++; if ({lat, err, ce_cnt} !== {32'd1, 1'b1, 32'd0}) begin miscompares++; $display("FAIL col_wr1023 got lat %0d err %b ce %0d exp 1 1 0", lat, err, ce_cnt); end
        apb_xfer(1'b0, 32'h0000_1FFC, 32'h0, 4'h0);
        vectors++; if ({lat, err, ce_cnt, rd} !== {32'd1, 1'b1, 32'd0, 32'h0}) begin miscompares++; $display("FAIL col_rd1023 got lat %0d err %b ce %0d data %h exp 1 1 0 0", lat, err, ce_cnt, rd); end
        apb_xfer(1'b0, 32'h0000_195C, 32'h0, 4'h0);
        vectors++; if ({lat, err, ce1, a1, rd} !== {32'd3, 1'b0, 3'b010, 10'd599, 32'h1234_5678}) begin miscompares++; $display("FAIL col_rd599 got lat %0d err %b ce %b addr %0d data %h exp 3 0 010 599 12345678", lat, err, ce1, a1, rd); end
    endtask

    task automatic test_back_to_back();
        int bad_wr;
        bad_wr = 0;
        for (int i = 0; i < 1024; i++) begin
            apb_xfer(1'b1, 32'h0000_2000 + 32'(i) * 4, 32'(i), 4'hF);
            if (lat !== 2 || err !== 1'b0 || ce1 !== 3'b001) bad_wr++;
        end
        vectors++; if (bad_wr !== 0) begin miscompares++; $display("FAIL ct_fill_writes bad %0d exp 0", bad_wr); end
        for (int i = 0; i < 1024; i++) begin
            apb_xfer(1'b0, 32'h0000_2000 + 32'(i) * 4, 32'h0, 4'hF);
            vectors++;
            if (rd !== 32'(i) || lat !== 3 || err !== 1'b0) begin
                miscompares++;
                $display("FAIL ct_readback word %0d got %h lat %0d err %b exp %h 3 0", i, rd, lat, err, 32'(i));
            end
        end
    endtask

    task automatic test_errors();
        apb_xfer(1'b0, 32'h0000_0002, 32'h0, 4'h0);
        vectors++; if ({lat, err, ce_cnt, rd} !== {32'd1, 1'b1, 32'd0, 32'h0}) begin miscompares++; $display("FAIL misaligned_rd got lat %0d err %b ce %0d data %h exp 1 1 0 0", lat, err, ce_cnt, rd); end
        apb_xfer(1'b0, 32'h0000_2024, 32'h0, 4'h0);
        vectors++; if (rd !== 32'd9) begin miscompares++; $display("FAIL rd_before_hold got %h exp 9", rd); end
        apb_xfer(1'b0, 32'h0000_3000, 32'h0, 4'h0);
`ifdef VGACHARGEN_APB_ID_REG_EN
        vectors++; if ({lat, err, ce_cnt, rd} !== {32'd3, 1'b0, 32'd0, 32'h5647_4331}) begin miscompares++; $display("FAIL id_rd got lat %0d err %b ce %0d data %h exp 3 0 0 56474331", lat, err, ce_cnt, rd); end
`else
        vectors++; if ({lat, err, ce_cnt, rd} !== {32'd1, 1'b1, 32'd0, 32'h0}) begin miscompares++; $display("FAIL region3_rd got lat %0d err %b ce %0d data %h exp 1 1 0 0", lat, err, ce_cnt, rd); end
`endif
        apb_xfer(1'b0, 32'h0000_3004, 32'h0, 4'h0);
        vectors++; if ({lat, err, ce_cnt} !== {32'd1, 1'b1, 32'd0}) begin miscompares++; $display("FAIL region3_w1_rd got lat %0d err %b ce %0d exp 1 1 0", lat, err, ce_cnt); end
        apb_xfer(1'b0, 32'h0000_2024, 32'h0, 4'h0);
        apb_xfer(1'b1, 32'h0000_0008, 32'h5555_AAAA, 4'hF);
        vectors++; if ({err, rd} !== {1'b0, 32'd9}) begin miscompares++; $display("FAIL prdata_hold_wr got err %b data %h exp 0 9", err, rd); end
        apb_xfer(1'b1, 32'h0000_3000, 32'h1, 4'hF);
        vectors++; if ({lat, err, ce_cnt, rd} !== {32'd1, 1'b1, 32'd0, 32'd9}) begin miscompares++; $display("FAIL region3_wr got lat %0d err %b ce %0d data %h exp 1 1 0 9", lat, err, ce_cnt, rd); end
    endtask

    task automatic test_partial();
        apb_xfer(1'b1, 32'h0000_1014, 32'h1122_3344, 4'hF);
        apb_xfer(1'b1, 32'h0000_1014, 32'h0000_AB00, 4'b0010);
        vectors++; if ({ce1, we1, be1, a1} !== {3'b010, 1'b1, 4'b0010, 10'd5}) begin miscompares++; $display("FAIL partial_ctl got ce %b we %b be %b addr %0d exp 010 1 0010 5", ce1, we1, be1, a1); end
        apb_xfer(1'b0, 32'h0000_1014, 32'h0, 4'h0);
        vectors++; if (rd !== 32'h1122_AB44) begin miscompares++; $display("FAIL partial_rd got %h exp 1122ab44", rd); end
        apb_xfer(1'b1, 32'h0000_1014, 32'hFFFF_FFFF, 4'h0);
        vectors++; if ({lat, err, ce1, we1, be1} !== {32'd2, 1'b0, 3'b010, 1'b0, 4'h0}) begin miscompares++; $display("FAIL zero_strb got lat %0d err %b ce %b we %b be %b exp 2 0 010 0 0000", lat, err, ce1, we1, be1); end
        apb_xfer(1'b0, 32'h0000_1014, 32'h0, 4'h0);
        vectors++; if (rd !== 32'h1122_AB44) begin miscompares++; $display("FAIL zero_strb_rd got %h exp 1122ab44", rd); end
    endtask

    task automatic test_reset_mid();
        int hits;
        hits = 0;
        apb_xfer(1'b1, 32'h0000_0000, 32'h7777_7777, 4'hF);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0000_201C; pstrb = 4'h0;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        vectors++; if ({pready, pslverr, cm_ce, col_ce, ct_ce, mem_we, mem_be} !== 10'h0) begin miscompares++; $display("FAIL rst_mid_ctl got %b exp 0", {pready, pslverr, cm_ce, col_ce, ct_ce, mem_we, mem_be}); end
        vectors++; if ({prdata, mem_addr, mem_wdata} !== 74'h0) begin miscompares++; $display("FAIL rst_mid_data got %h/%h/%h exp 0", prdata, mem_addr, mem_wdata); end
        rst = 1'b0; psel = 1'b0; penable = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (pready) hits++;
        end
        vectors++; if (hits !== 0) begin miscompares++; $display("FAIL rst_mid_pready got %0d exp 0", hits); end
        apb_xfer(1'b1, 32'h0000_0000, 32'hCAFE_F00D, 4'hF);
        vectors++; if ({lat, err, ce1, we1} !== {32'd2, 1'b0, 3'b100, 1'b1}) begin miscompares++; $display("FAIL post_rst_wr got lat %0d err %b ce %b we %b exp 2 0 100 1", lat, err, ce1, we1); end
        apb_xfer(1'b0, 32'h0000_0000, 32'h0, 4'h0);
        vectors++; if (rd !== 32'hCAFE_F00D) begin miscompares++; $display("FAIL post_rst_rd got %h exp cafef00d", rd); end
    endtask

    initial begin
        test_reset();
        test_enable_no_setup();
        test_write_basic();
        test_colmap_bounds();
        test_back_to_back();
        test_errors();
        test_partial();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
